// File: rtl/cnn_conv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cnn_conv_sequencer
// Description : Sequences one valid-mode KxK convolution over an IMG_W x IMG_H
//               image. For every output window it issues K*K image-RAM reads
//               (kc fastest), drives one-cycle-delayed MAC strobes/tap indices,
//               waits for the MAC result and pushes it into the output FIFO.
// Ports       :
//   s00_axi_aclk / s00_axi_aresetn : clock, async active-low reset
//   start, abort                   : control (start pulse, sync abort)
//   img_rd_en, img_rd_addr         : image RAM read port
//   mac_en/first/last, ker_idx     : MAC control, aligned with RAM read data
//   mac_res_valid                  : MAC result ready
//   fifo_full, fifo_wr_en          : output FIFO push
//   busy, done, out_count          : status
// Revision    : 1.0 - initial release
// ============================================================================
module cnn_conv_sequencer #(
    parameter int IMG_W  = 224,
    parameter int IMG_H  = 224,
    parameter int K      = 3,
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              s00_axi_aclk,
    input  logic              s00_axi_aresetn,
    input  logic              start,
    input  logic              abort,
    output logic              img_rd_en,
    output logic [ADDR_W-1:0] img_rd_addr,
    output logic              mac_en,
    output logic              mac_first,
    output logic              mac_last,
    output logic [3:0]        ker_idx,
    input  logic              mac_res_valid,
    input  logic              fifo_full,
    output logic              fifo_wr_en,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  out_count
);

    localparam int              OH       = IMG_H - K + 1;
    localparam int              OW       = IMG_W - K + 1;
    localparam logic [3:0]      K_LAST   = 4'(K - 1);
    localparam logic [3:0]      TAP_LAST = 4'(K * K - 1);
    localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(OW - 1);
    localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(OH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_PUSH  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  row_q, row_d, col_q, col_d;
    logic [3:0]         kr_q, kr_d, kc_q, kc_d, tap_q, tap_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mac_en_q, mac_first_q, mac_last_q;
    logic [3:0]         ker_idx_q;
    logic               w_rd_en, w_wr_en;
    logic [ADDR_W-1:0]  w_addr;

    // Pixel address of the current tap relative to the window origin.
    assign w_addr = (row_q + ADDR_W'(kr_q)) * ADDR_W'(IMG_W) + col_q + ADDR_W'(kc_q);

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        kr_d    = kr_q;
        kc_d    = kc_q;
        tap_d   = tap_q;
        done_d  = done_q;
        cnt_d   = cnt_q;
        w_rd_en = 1'b0;
        w_wr_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                // abort has priority over a simultaneous start
                if (start && !abort) begin
                    state_d = S_FETCH;
                    done_d  = 1'b0;
                    cnt_d   = '0;
                    row_d   = '0;
                    col_d   = '0;
                    kr_d    = '0;
                    kc_d    = '0;
                    tap_d   = '0;
                end
            end
            S_FETCH: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    w_rd_en = 1'b1;
                    tap_d   = tap_q + 4'd1;
                    if (kc_q == K_LAST) begin
                        kc_d = '0;
                        if (kr_q == K_LAST) begin
                            // tap counters rewind here so the next FETCH starts clean
                            kr_d    = '0;
                            tap_d   = '0;
                            state_d = S_WAIT;
                        end else begin
                            kr_d = kr_q + 4'd1;
                        end
                    end else begin
                        kc_d = kc_q + 4'd1;
                    end
                end
            end
            S_WAIT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (mac_res_valid) begin
                    state_d = S_PUSH;
                end
            end
            S_PUSH: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (!fifo_full) begin
                    w_wr_en = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = S_FETCH;
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q == ROW_LAST) begin
                            row_d   = '0;
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            row_d = row_q + ADDR_W'(1);
                        end
                    end else begin
                        col_d = col_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            kr_q        <= '0;
            kc_q        <= '0;
            tap_q       <= '0;
            done_q      <= 1'b0;
            cnt_q       <= '0;
            mac_en_q    <= 1'b0;
            mac_first_q <= 1'b0;
            mac_last_q  <= 1'b0;
            ker_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            kr_q        <= kr_d;
            kc_q        <= kc_d;
            tap_q       <= tap_d;
            done_q      <= done_d;
            cnt_q       <= cnt_d;
            // One-cycle delay matches the image RAM read latency; since reads
            // are suppressed during abort, the strobe pipeline drains to 0.
            mac_en_q    <= w_rd_en;
            mac_first_q <= w_rd_en && (tap_q == 4'd0);
            mac_last_q  <= w_rd_en && (tap_q == TAP_LAST);
            ker_idx_q   <= w_rd_en ? tap_q : 4'd0;
        end
    end

    assign img_rd_en   = w_rd_en;
    assign img_rd_addr = w_rd_en ? w_addr : '0;
    assign fifo_wr_en  = w_wr_en;
    assign mac_en      = mac_en_q;
    assign mac_first   = mac_first_q;
    assign mac_last    = mac_last_q;
    assign ker_idx     = ker_idx_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign out_count   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cnn_conv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cnn_conv_sequencer
// Description : Self-checking bench for cnn_conv_sequencer (5x4 image, 3x3
//               kernel, 6 windows). A window-level model predicts read
//               addresses, MAC alignment, FIFO pushes and status each cycle;
//               directed scenarios add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cnn_conv_sequencer;

    localparam int IMG_W  = 5;
    localparam int IMG_H  = 4;
    localparam int K      = 3;
    localparam int ADDR_W = 16;
    localparam int CNT_W  = 16;
    localparam int OW     = IMG_W - K + 1;
    localparam int OH     = IMG_H - K + 1;
    localparam int NWIN   = OW * OH;
    localparam int TAPS   = K * K;
    localparam int L      = 2;

    logic              clk;
    logic              rst_n;
    logic              start, abort, fifo_full;
    logic              mac_res_valid = 1'b0;
    logic              img_rd_en, mac_en, mac_first, mac_last, fifo_wr_en, busy, done;
    logic [ADDR_W-1:0] img_rd_addr;
    logic [3:0]        ker_idx;
    logic [CNT_W-1:0]  out_count;

    int tests  = 0;
    int failed = 0;

    cnn_conv_sequencer #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
    ) dut (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
        .start(start), .abort(abort),
        .img_rd_en(img_rd_en), .img_rd_addr(img_rd_addr),
        .mac_en(mac_en), .mac_first(mac_first), .mac_last(mac_last),
        .ker_idx(ker_idx), .mac_res_valid(mac_res_valid),
        .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
        .busy(busy), .done(done), .out_count(out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // MAC stand-in: result ready L cycles after the window's final read.
    int mac_cnt = 0;
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            mac_cnt       = 0;
            mac_res_valid = 1'b0;
        end else begin
            mac_res_valid = 1'b0;
            if (mac_cnt > 0) begin
                mac_cnt--;
                if (mac_cnt == 0) mac_res_valid = 1'b1;
            end
            if (mac_last) mac_cnt = L - 1;
        end
    end

    // ---------------- window-level reference model ----------------
    int  exp_q[$];
    int  rd_log[$];
    bit  m_busy, m_done, pending, prev_rd, old_busy;
    int  m_count, run_reads, prev_tap, wr_run, first_cnt, last_cnt;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_ctrl", 32'({img_rd_en, mac_en, mac_first, mac_last, ker_idx,
                                 fifo_wr_en, busy, done}), 0);
            chk("rst_addr", 32'(img_rd_addr), 0);
            chk("rst_count", 32'(out_count), 0);
            m_busy = 0; m_done = 0; pending = 0; prev_rd = 0;
            m_count = 0; run_reads = 0;
            exp_q.delete();
        end else begin
            old_busy = m_busy;
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            chk("out_count", 32'(out_count), m_count);
            if (img_rd_en) begin
                if (!old_busy || abort || exp_q.size() == 0)
                    chk("rd_unexpected", 1, 0);
                else
                    chk("rd_addr", 32'(img_rd_addr), exp_q.pop_front());
                rd_log.push_back(int'(img_rd_addr));
            end
            chk("mac_en", 32'(mac_en), 32'(prev_rd));
            chk("mac_first", 32'(mac_first), 32'(prev_rd && prev_tap == 0));
            chk("mac_last", 32'(mac_last), 32'(prev_rd && prev_tap == TAPS - 1));
            if (prev_rd) chk("ker_idx", 32'(ker_idx), prev_tap);
            chk("fifo_wr_en", 32'(fifo_wr_en), 32'(old_busy && pending && !fifo_full && !abort));
            if (mac_first) first_cnt++;
            if (mac_last)  last_cnt++;

            prev_rd = img_rd_en;
            if (img_rd_en) begin
                prev_tap = run_reads % TAPS;
                run_reads++;
            end
            if (fifo_wr_en) begin
                wr_run++;
                pending = 0;
                m_count++;
                if (m_count == NWIN) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end
            // a result counts only once every tap of the current window was read
            if (old_busy && !abort && mac_res_valid && !pending &&
                run_reads == TAPS * (m_count + 1))
                pending = 1;
            if (old_busy && abort) begin
                m_busy  = 0;
                pending = 0;
                exp_q.delete();
            end else if (!old_busy && start && !abort) begin
                m_busy = 1; m_done = 0; m_count = 0; pending = 0;
                run_reads = 0; wr_run = 0; first_cnt = 0; last_cnt = 0;
                rd_log.delete();
                exp_q.delete();
                for (int w = 0; w < NWIN; w++)
                    for (int kr = 0; kr < K; kr++)
                        for (int kc = 0; kc < K; kc++)
                            exp_q.push_back((w / OW + kr) * IMG_W + (w % OW) + kc);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_count(input int target, input string name);
        int n = 0;
        while (int'(out_count) != target && n < 3000) begin tick(); n++; end
        chk(name, 32'(out_count), target);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 3000) begin tick(); n++; end
        chk(name, 32'(done), 1);
    endtask

    task automatic check_full_run(input string tag);
        chk({tag, "_count"}, 32'(out_count), NWIN);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_writes"}, wr_run, NWIN);
        chk({tag, "_reads"}, rd_log.size(), NWIN * TAPS);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, w0, r0;
        int win0[9];
        win0 = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
        start = 0; abort = 0; fifo_full = 0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_count", 32'(out_count), 0);

        // Run A: clean run, window-0 addresses, runtime
        pulse_start();
        chk("a_busy_after_start", 32'(busy), 1);
        n = 0;
        while (!done && n < 200) begin tick(); n++; end
        chk("a_runtime", n, NWIN * (TAPS + L + 1));
        check_full_run("a");
        chk("a_done", 32'(done), 1);
        if (rd_log.size() == NWIN * TAPS) begin
            for (int i = 0; i < 9; i++) chk("a_win0_addr", rd_log[i], win0[i]);
            chk("a_last_addr", rd_log[NWIN * TAPS - 1], 19);
        end
        chk("a_first_pulses", first_cnt, NWIN);
        chk("a_last_pulses", last_cnt, NWIN);

        // Run B: restart after done, start during FETCH, FIFO backpressure
        pulse_start();
        chk("b_done_cleared", 32'(done), 0);
        chk("b_count_cleared", 32'(out_count), 0);
        wait_count(2, "b_reach_2");
        repeat (3) tick();
        pulse_start();
        chk("b_start_ignored_count", 32'(out_count), 2);
        n = 0;
        while (!mac_res_valid && n < 100) begin tick(); n++; end
        chk("b_res_seen", 32'(mac_res_valid), 1);
        fifo_full = 1'b1;
        w0 = wr_run;
        repeat (20) tick();
        chk("b_no_write_while_full", wr_run, w0);
        fifo_full = 1'b0;
        tick();
        chk("b_write_after_release", wr_run, w0 + 1);
        wait_done("b_done");
        check_full_run("b");

        // Run C: abort in WAIT_RES of window 3
        pulse_start();
        wait_count(3, "c_reach_3");
        n = 0;
        while (!mac_last && n < 100) begin tick(); n++; end
        chk("c_in_wait", 32'(mac_last), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("c_abort_busy", 32'(busy), 0);
        chk("c_abort_done", 32'(done), 0);
        chk("c_abort_count", 32'(out_count), 3);
        r0 = rd_log.size();
        w0 = wr_run;
        repeat (30) tick();
        chk("c_no_reads", rd_log.size(), r0);
        chk("c_no_writes", wr_run, w0);
        chk("c_count_held", 32'(out_count), 3);

        // abort and start together in IDLE: stays idle
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("d_abort_wins", 32'(busy), 0);
        tick();
        chk("d_still_idle", 32'(busy), 0);

        // Run E: async reset mid-FETCH, then full run from window 0
        pulse_start();
        n = 0;
        while (!img_rd_en && n < 50) begin tick(); n++; end
        repeat (3) tick();
        #1 rst_n = 1'b0;
        #1;
        chk("e_rst_now_ctrl", 32'({img_rd_en, mac_en, mac_first, mac_last, ker_idx,
                                   fifo_wr_en, busy, done}), 0);
        chk("e_rst_now_addr", 32'(img_rd_addr), 0);
        repeat (2) tick();
        #1 rst_n = 1'b1;
        tick();
        pulse_start();
        wait_done("e_done");
        check_full_run("e");
        if (rd_log.size() > 0) chk("e_first_addr", rd_log[0], 0);

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
